// File: rtl/pong_ball_ctrl.sv
// Pong ball engine: per-tick motion, wall/paddle bounces, goal detection and serve sequencing.
// Optional build macro BALL_SPEEDUP_EN: each paddle hit raises |vx| by one up to MAX_SPEED.
module pong_ball_ctrl #(
    parameter int unsigned FIELD_W    = 640,
    parameter int unsigned FIELD_H    = 360,
    parameter int unsigned X_W        = 11,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned BALL_SIZE  = 8,
    parameter int unsigned PAD_H      = 64,
    parameter int unsigned PAD_L_X    = 16,
    parameter int unsigned PAD_R_X    = 624,
    parameter int unsigned SPEED      = 1,
    parameter int unsigned MAX_SPEED  = 4,
    parameter int unsigned SERVE_WAIT = 60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           serve,
    input  logic [Y_W-1:0] bar_1_y,
    input  logic [Y_W-1:0] bar_2_y,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           point_1,
    output logic           point_2,
    output logic           hit,
    output logic           in_play
);

    localparam int unsigned XS_W  = X_W + 1;
    localparam int unsigned YS_W  = Y_W + 2;
    localparam int unsigned CNT_W = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;
    localparam int unsigned V_TOP = (MAX_SPEED > SPEED) ? MAX_SPEED : SPEED;
    localparam int unsigned V_W   = $clog2(V_TOP + 1);
    localparam int unsigned XC    = (FIELD_W - BALL_SIZE) / 2;
    localparam int unsigned YC    = (FIELD_H - BALL_SIZE) / 2;

    localparam logic signed [XS_W-1:0] X_ZERO   = '0;
    localparam logic signed [XS_W-1:0] BALL_X_S = XS_W'(BALL_SIZE);
    localparam logic signed [XS_W-1:0] PAD_L_S  = XS_W'(PAD_L_X);
    localparam logic signed [XS_W-1:0] PAD_R_S  = XS_W'(PAD_R_X);
    localparam logic signed [XS_W-1:0] X_MAX_S  = XS_W'(FIELD_W - BALL_SIZE);
    localparam logic signed [YS_W-1:0] Y_ZERO   = '0;
    localparam logic signed [YS_W-1:0] Y_SPD    = YS_W'(SPEED);
    localparam logic signed [YS_W-1:0] BALL_Y_S = YS_W'(BALL_SIZE);
    localparam logic signed [YS_W-1:0] PAD_H_S  = YS_W'(PAD_H);
    localparam logic signed [YS_W-1:0] Y_MAX_S  = YS_W'(FIELD_H - BALL_SIZE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_SCORE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             vx_neg_q, vx_neg_d;
    logic [V_W-1:0]   vx_mag_q, vx_mag_d;
    logic             vy_neg_q, vy_neg_d;
    logic             point_1_q, point_1_d;
    logic             point_2_q, point_2_d;
    logic             hit_q, hit_d;
    logic             in_play_q, in_play_d;

    logic signed [XS_W-1:0] x_s, vx_s, nx;
    logic signed [YS_W-1:0] y_s, vy_s, ny, ny_bot;
    logic signed [YS_W-1:0] bar1_top, bar1_bot, bar2_top, bar2_bot;
    logic                   ov_1, ov_2, hit_l, hit_r, goal_1, goal_2;
    logic [V_W-1:0]         vx_mag_up;

`ifdef BALL_SPEEDUP_EN
    assign vx_mag_up = (vx_mag_q >= V_W'(MAX_SPEED)) ? V_W'(MAX_SPEED) : vx_mag_q + V_W'(1);
`else
    assign vx_mag_up = V_W'(SPEED);
`endif

    // Candidate position and contact/goal decisions for the current tick
    always_comb begin
        x_s      = $signed(XS_W'(x_q));
        vx_s     = vx_neg_q ? -$signed(XS_W'(vx_mag_q)) : $signed(XS_W'(vx_mag_q));
        nx       = x_s + vx_s;
        y_s      = $signed(YS_W'(y_q));
        vy_s     = vy_neg_q ? -Y_SPD : Y_SPD;
        ny       = y_s + vy_s;
        ny_bot   = ny + BALL_Y_S;
        bar1_top = $signed(YS_W'(bar_1_y));
        bar1_bot = bar1_top + PAD_H_S;
        bar2_top = $signed(YS_W'(bar_2_y));
        bar2_bot = bar2_top + PAD_H_S;
        ov_1     = (ny_bot > bar1_top) && (ny < bar1_bot);
        ov_2     = (ny_bot > bar2_top) && (ny < bar2_bot);
        hit_l    = vx_neg_q && (nx <= PAD_L_S) && ov_1;
        hit_r    = !vx_neg_q && ((nx + BALL_X_S) >= PAD_R_S) && ov_2;
        goal_2   = !hit_l && !hit_r && (nx <= X_ZERO);
        goal_1   = !hit_l && !hit_r && (nx >= X_MAX_S);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_neg_d  = vx_neg_q;
        vx_mag_d  = vx_mag_q;
        vy_neg_d  = vy_neg_q;
        point_1_d = 1'b0;
        point_2_d = 1'b0;
        hit_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (serve) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(SERVE_WAIT - 1)) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (ny <= Y_ZERO) begin
                        y_d      = '0;
                        vy_neg_d = 1'b0;
                    end else if (ny >= Y_MAX_S) begin
                        y_d      = Y_W'(FIELD_H - BALL_SIZE);
                        vy_neg_d = 1'b1;
                    end else begin
                        y_d = Y_W'(ny);
                    end

                    if (hit_l) begin
                        x_d      = X_W'(PAD_L_X);
                        vx_neg_d = 1'b0;
                        vx_mag_d = vx_mag_up;
                        hit_d    = 1'b1;
                    end else if (hit_r) begin
                        x_d      = X_W'(PAD_R_X - BALL_SIZE);
                        vx_neg_d = 1'b1;
                        vx_mag_d = vx_mag_up;
                        hit_d    = 1'b1;
                    end else if (goal_2 || goal_1) begin
                        // Ball freezes at its last legal spot for the score cycle
                        x_d       = x_q;
                        y_d       = y_q;
                        vy_neg_d  = vy_neg_q;
                        point_1_d = goal_1;
                        point_2_d = goal_2;
                        state_d   = S_SCORE;
                    end else begin
                        x_d = X_W'(nx);
                    end
                end
            end
            S_SCORE: begin
                x_d      = X_W'(XC);
                y_d      = Y_W'(YC);
                vy_neg_d = 1'b1;
                vx_neg_d = point_2_q;
                vx_mag_d = V_W'(SPEED);
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_play_d = (state_d == S_PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            x_q       <= X_W'(XC);
            y_q       <= Y_W'(YC);
            vx_neg_q  <= 1'b0;
            vx_mag_q  <= V_W'(SPEED);
            vy_neg_q  <= 1'b1;
            point_1_q <= 1'b0;
            point_2_q <= 1'b0;
            hit_q     <= 1'b0;
            in_play_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_neg_q  <= vx_neg_d;
            vx_mag_q  <= vx_mag_d;
            vy_neg_q  <= vy_neg_d;
            point_1_q <= point_1_d;
            point_2_q <= point_2_d;
            hit_q     <= hit_d;
            in_play_q <= in_play_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign point_1 = point_1_q;
    assign point_2 = point_2_q;
    assign hit     = hit_q;
    assign in_play = in_play_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Scoreboard bench for pong_ball_ctrl: a behavioural model queues expected outputs each clock.
module tb_pong_ball_ctrl;

    localparam int XC = 316;
    localparam int YC = 176;
    localparam int SERVE_WAIT = 60;

    logic        clk;
    logic        reset, tick, serve;
    logic [9:0]  bar_1_y, bar_2_y;
    logic [10:0] x;
    logic [9:0]  y;
    logic        point_1, point_2, hit, in_play;

    pong_ball_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .serve   (serve),
        .bar_1_y (bar_1_y),
        .bar_2_y (bar_2_y),
        .x       (x),
        .y       (y),
        .point_1 (point_1),
        .point_2 (point_2),
        .hit     (hit),
        .in_play (in_play)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [3:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    int   m_st, m_x, m_y, m_vx, m_vy, m_cnt;
    bit   m_p1, m_p2, m_hit;
    int   l_mode, r_mode;
    bit   rand_serve;
    bit   seen_p1, seen_p2, seen_hit;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int bar_for(input int mode, input int yy);
        if (mode == 0) return (yy > 20) ? yy - 20 : 0;
        return (yy < YC) ? 296 : 0;
    endfunction

    function automatic int next_mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
`ifdef BALL_SPEEDUP_EN
        return (a + 1 > 4) ? 4 : a + 1;
`else
        return 1;
`endif
    endfunction

    task automatic model_reset();
        m_st = 0; m_x = XC; m_y = YC; m_vx = 1; m_vy = -1; m_cnt = 0;
        m_p1 = 0; m_p2 = 0; m_hit = 0;
    endtask

    task automatic model_step();
        int nx, ny, yy, nvy, b1, b2;
        bit p1_prev, hl, hr;
        p1_prev = m_p1;
        m_p1 = 0; m_p2 = 0; m_hit = 0;
        b1 = int'(bar_1_y);
        b2 = int'(bar_2_y);
        if (reset) begin
            model_reset();
        end else begin
            case (m_st)
                0: if (serve) m_st = 1;
                1: if (tick) begin
                    if (m_cnt == SERVE_WAIT - 1) begin m_st = 2; m_cnt = 0; end
                    else m_cnt++;
                end
                2: if (tick) begin
                    nx = m_x + m_vx;
                    ny = m_y + m_vy;
                    nvy = m_vy; yy = ny;
                    if (ny <= 0) begin yy = 0; nvy = 1; end
                    else if (ny >= 352) begin yy = 352; nvy = -1; end
                    hl = (m_vx < 0) && (nx <= 16) && (ny + 8 > b1) && (ny < b1 + 64);
                    hr = (m_vx > 0) && (nx + 8 >= 624) && (ny + 8 > b2) && (ny < b2 + 64);
                    if (hl) begin
                        m_x = 16; m_vx = next_mag(m_vx); m_hit = 1; m_y = yy; m_vy = nvy;
                    end else if (hr) begin
                        m_x = 616; m_vx = -next_mag(m_vx); m_hit = 1; m_y = yy; m_vy = nvy;
                    end else if (nx <= 0) begin
                        m_p2 = 1; m_st = 3;
                    end else if (nx >= 632) begin
                        m_p1 = 1; m_st = 3;
                    end else begin
                        m_x = nx; m_y = yy; m_vy = nvy;
                    end
                end
                default: begin
                    m_x = XC; m_y = YC; m_vy = -1;
                    m_vx = p1_prev ? 1 : -1;
                    m_cnt = 0; m_st = 1;
                end
            endcase
        end
    endtask

    // One clock: model steps at the edge, its prediction is queued, then popped against the DUT
    task automatic cycle(input logic tk);
        exp_t e;
        tick = tk;
        @(posedge clk);
        model_step();
        e.x = 11'(m_x);
        e.y = 10'(m_y);
        e.flags = {m_p1, m_p2, m_hit, (m_st == 2)};
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check_eq("x", 32'(x), 32'(e.x));
        check_eq("y", 32'(y), 32'(e.y));
        check_eq("flags", 32'({point_1, point_2, hit, in_play}), 32'(e.flags));
        if (point_1) seen_p1 = 1;
        if (point_2) seen_p2 = 1;
        if (hit)     seen_hit = 1;
        bar_1_y = 10'(bar_for(l_mode, m_y));
        bar_2_y = 10'(bar_for(r_mode, m_y));
        if (rand_serve) serve = 1'($urandom_range(0, 1));
    endtask

    task automatic tick_once(input bit rst_on_point);
        cycle(1'b1);
        if (rst_on_point && (point_1 || point_2)) reset = 1'b1;
        cycle(1'b0);
        reset = 1'b0;
    endtask

    task automatic serve_wait();
        for (int i = 1; i <= SERVE_WAIT; i++) begin
            tick_once(1'b0);
            if (i == SERVE_WAIT - 1) check_eq("wait_not_play", 32'(in_play), 32'd0);
            if (i == SERVE_WAIT)     check_eq("wait_to_play", 32'(in_play), 32'd1);
        end
    endtask

    task automatic serve_start();
        serve = 1'b1;
        cycle(1'b0);
        serve = 1'b0;
        serve_wait();
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; serve = 1'b0;
        bar_1_y = '0; bar_2_y = '0;
        l_mode = 0; r_mode = 0; rand_serve = 0;
        seen_p1 = 0; seen_p2 = 0; seen_hit = 0;
        model_reset();

        repeat (3) cycle(1'b0);
        check_eq("rst_x", 32'(x), 32'(XC));
        check_eq("rst_y", 32'(y), 32'(YC));
        check_eq("rst_pulses", 32'({point_1, point_2, hit, in_play}), 32'd0);
        reset = 1'b0;

        repeat (5) tick_once(1'b0);
        check_eq("idle_x", 32'(x), 32'(XC));

        serve_start();
        tick_once(1'b0);
        check_eq("first_x", 32'(x), 32'd317);
        check_eq("first_y", 32'(y), 32'd175);

        seen_hit = 0;
        for (int i = 0; i < 2000 && !seen_hit; i++) tick_once(1'b0);
        check_eq("hit_r_seen", 32'(seen_hit), 32'd1);
        check_eq("hit_r_x", 32'(x), 32'd616);
        seen_hit = 0;
        for (int i = 0; i < 2000 && !seen_hit; i++) tick_once(1'b0);
        check_eq("hit_l_seen", 32'(seen_hit), 32'd1);
        check_eq("hit_l_x", 32'(x), 32'd16);
        seen_hit = 0;
        for (int i = 0; i < 2000 && !seen_hit; i++) tick_once(1'b0);
        check_eq("hit_r2_seen", 32'(seen_hit), 32'd1);

        // Left paddle dodges the ball: point for player 2, serve goes left
        l_mode = 1; seen_p2 = 0;
        for (int i = 0; i < 2000 && !seen_p2; i++) tick_once(1'b0);
        check_eq("p2_seen", 32'(seen_p2), 32'd1);
        check_eq("score_x", 32'(x), 32'(XC));
        check_eq("score_y", 32'(y), 32'(YC));
        check_eq("score_ip", 32'(in_play), 32'd0);
        serve_wait();
        tick_once(1'b0);
        check_eq("serve_left_x", 32'(x), 32'd315);
        check_eq("serve_left_y", 32'(y), 32'd175);

        // Right paddle dodges: point for player 1, then reset mid-WAIT
        l_mode = 0; r_mode = 1; seen_p1 = 0;
        for (int i = 0; i < 2000 && !seen_p1; i++) tick_once(1'b0);
        check_eq("p1_seen", 32'(seen_p1), 32'd1);
        repeat (10) tick_once(1'b0);
        reset = 1'b1;
        cycle(1'b0);
        reset = 1'b0;
        check_eq("rst_wait_ip", 32'(in_play), 32'd0);
        repeat (SERVE_WAIT + 10) tick_once(1'b0);
        check_eq("no_serve_ip", 32'(in_play), 32'd0);
        check_eq("no_serve_x", 32'(x), 32'(XC));

        serve_start();
        r_mode = 0; rand_serve = 1;
        repeat (400) tick_once(1'b0);
        l_mode = 1; seen_p2 = 0;
        for (int i = 0; i < 2000 && !seen_p2; i++) tick_once(1'b1);
        check_eq("p2b_seen", 32'(seen_p2), 32'd1);
        rand_serve = 0; serve = 1'b0;
        check_eq("rst_score_x", 32'(x), 32'(XC));
        repeat (SERVE_WAIT + 2) tick_once(1'b0);
        check_eq("rst_score_idle", 32'(in_play), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
